// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential ALU: the CMD_* opcode encoding
//   (command[31:28]), the FSM state encoding and the default datapath width.
//   Imported by the interface, the iterative core and the top level.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 32;

    typedef logic [3:0] cmd_t;

    // Opcode encoding shared with the rest of the core.
    // Codes 4'hA..4'hF are unassigned and are reported as bad_op.
    localparam cmd_t CMD_MOV = 4'h0;
    localparam cmd_t CMD_ADD = 4'h1;
    localparam cmd_t CMD_SUB = 4'h2;
    localparam cmd_t CMD_MUL = 4'h3;
    localparam cmd_t CMD_DIV = 4'h4;
    localparam cmd_t CMD_SHR = 4'h5;
    localparam cmd_t CMD_SHL = 4'h6;
    localparam cmd_t CMD_XOR = 4'h7;
    localparam cmd_t CMD_AND = 4'h8;
    localparam cmd_t CMD_OR  = 4'h9;

    // FSM state encoding
    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Request/response bundle between a requester (master) and alu_seq (slave).
//   Handshake: the master raises start with cmd_code/src0/src1 stable; the
//   request is taken on the rising clock edge where start is high and busy is
//   low. start while busy is dropped, never queued. done pulses for exactly one
//   cycle once dst/dst_h/src0_out and the flags hold the new result; those
//   outputs then hold until the next completion.
//   Signals: start, cmd_code, src0, src1 (master -> slave);
//            busy, done, dst, dst_h, src0_out, zero, dz, bad_op,
//            dbg_state (FSM state for observation) (slave -> master).
interface alu_seq_if #(
    parameter int DATA_W = 32
);
    import alu_seq_pkg::*;

    logic               start;
    logic [3:0]         cmd_code;
    logic [DATA_W-1:0]  src0;
    logic [DATA_W-1:0]  src1;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  dst;
    logic [DATA_W-1:0]  dst_h;
    logic [DATA_W-1:0]  src0_out;
    logic               zero;
    logic               dz;
    logic               bad_op;
    logic [STATE_W-1:0] dbg_state;

    modport master (
        output start, cmd_code, src0, src1,
        input  busy, done, dst, dst_h, src0_out, zero, dz, bad_op, dbg_state
    );

    modport slave (
        input  start, cmd_code, src0, src1,
        output busy, done, dst, dst_h, src0_out, zero, dz, bad_op, dbg_state
    );

endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv
//   Iterative unsigned multiply / restoring divide core, one bit per step.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     load            capture operands, clear accumulator and counter
//     step            perform one iteration
//     is_div          at load: 1 = divide, 0 = multiply
//     op_a, op_b      at load: multiplier/dividend, multiplicand/divisor
//     lo_next/hi_next result registers after the current step (product lo/hi
//                     or quotient/remainder); valid as final on the last step
//     last            current step is the final (DATA_W-th) one
module alu_seq_muldiv import alu_seq_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] lo_next,
    output logic [DATA_W-1:0] hi_next,
    output logic              last
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_trial;

    always_comb begin
        // Multiply: {hi,lo} holds {partial product, remaining multiplier};
        // add the multiplicand into hi when the multiplier LSB is set, then
        // shift the whole pair right including the carry.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Divide: hi is the partial remainder, lo shifts the dividend out at
        // the top and the quotient bits in at the bottom. rem_shift is always
        // below 2*divisor, so bit DATA_W of the trial difference is the borrow.
        rem_shift = {hi_q, lo_q[DATA_W-1]};
        rem_trial = rem_shift - {1'b0, b_q};

        if (is_div_q) begin
            if (rem_trial[DATA_W]) begin
                hi_next = rem_shift[DATA_W-1:0];
                lo_next = {lo_q[DATA_W-2:0], 1'b0};
            end else begin
                hi_next = rem_trial[DATA_W-1:0];
                lo_next = {lo_q[DATA_W-2:0], 1'b1};
            end
        end else begin
            hi_next = mul_sum[DATA_W:1];
            lo_next = {mul_sum[0], lo_q[DATA_W-1:1]};
        end

        last = (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_comb begin
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        if (load) begin
            b_d      = op_b;
            hi_d     = '0;
            lo_d     = op_a;
            is_div_d = is_div;
            cnt_d    = '0;
        end else if (step) begin
            hi_d  = hi_next;
            lo_d  = lo_next;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Multi-cycle ALU with a start/done handshake. Single-cycle ops (MOV ADD SUB
//   SHR SHL XOR AND OR), divide-by-zero and unknown opcodes complete at the
//   accept edge; MUL and DIV iterate DATA_W cycles in alu_seq_muldiv.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset (aborts any operation, no done)
//     bus  alu_seq_if slave: start/cmd_code/src0/src1 in; busy/done/dst/
//          dst_h/src0_out/zero/dz/bad_op/dbg_state out
module alu_seq import alu_seq_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    logic [STATE_W-1:0] state_q, state_d;
    logic [DATA_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0]  dst_h_q, dst_h_d;
    logic [DATA_W-1:0]  src0_out_q, src0_out_d;
    logic               zero_q, zero_d;
    logic               dz_q, dz_d;
    logic               bad_op_q, bad_op_d;

    logic               accept;
    logic               res_we;
    logic [DATA_W-1:0]  res;
    logic [DATA_W-1:0]  res_h;
    logic [DATA_W:0]    add_sum;
    logic [DATA_W:0]    sub_diff;
    logic               shift_big;

    logic               core_load;
    logic               core_step;
    logic               core_is_div;
    logic [DATA_W-1:0]  core_lo;
    logic [DATA_W-1:0]  core_hi;
    logic               core_last;

    alu_seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (core_is_div),
        .op_a    (bus.src0),
        .op_b    (bus.src1),
        .lo_next (core_lo),
        .hi_next (core_hi),
        .last    (core_last)
    );

    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        dst_h_d     = dst_h_q;
        src0_out_d  = src0_out_q;
        zero_d      = zero_q;
        dz_d        = dz_q;
        bad_op_d    = bad_op_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        core_is_div = 1'b0;
        res_we      = 1'b0;
        res         = '0;
        res_h       = '0;

        add_sum   = {1'b0, bus.src0} + {1'b0, bus.src1};
        sub_diff  = {1'b0, bus.src0} - {1'b0, bus.src1};
        shift_big = (bus.src1 >= SHIFT_LIMIT);

        // DONE also accepts, which gives back-to-back operation.
        accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

        case (state_q)
            ST_MUL, ST_DIV: begin
                core_step = 1'b1;
                // Results are published only on the final step so dst/dst_h
                // never show intermediate accumulator values.
                if (core_last) begin
                    state_d    = ST_DONE;
                    dst_d      = core_lo;
                    dst_h_d    = core_hi;
                    src0_out_d = '0;
                    zero_d     = (core_lo == '0);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        if (accept) begin
            state_d    = ST_DONE;
            dz_d       = 1'b0;
            bad_op_d   = 1'b0;
            src0_out_d = '0;
            res_we     = 1'b1;
            case (bus.cmd_code)
                CMD_MOV: begin
                    res        = bus.src0;
                    src0_out_d = bus.src1;
                end
                CMD_ADD: begin
                    res   = add_sum[DATA_W-1:0];
                    res_h = {{(DATA_W-1){1'b0}}, add_sum[DATA_W]};
                end
                CMD_SUB: begin
                    res   = sub_diff[DATA_W-1:0];
                    res_h = {DATA_W{sub_diff[DATA_W]}};
                end
                CMD_SHR: res = shift_big ? '0 : (bus.src0 >> bus.src1[SHAMT_W-1:0]);
                CMD_SHL: res = shift_big ? '0 : (bus.src0 << bus.src1[SHAMT_W-1:0]);
                CMD_XOR: res = bus.src0 ^ bus.src1;
                CMD_AND: res = bus.src0 & bus.src1;
                CMD_OR:  res = bus.src0 | bus.src1;
                CMD_MUL: begin
                    res_we    = 1'b0;
                    core_load = 1'b1;
                    state_d   = ST_MUL;
                end
                CMD_DIV: begin
                    if (bus.src1 == '0) begin
                        res   = '1;
                        res_h = bus.src0;
                        dz_d  = 1'b1;
                    end else begin
                        res_we      = 1'b0;
                        core_load   = 1'b1;
                        core_is_div = 1'b1;
                        state_d     = ST_DIV;
                    end
                end
                default: begin
                    // Unknown opcode: flag it and complete without touching dst.
                    res_we   = 1'b0;
                    bad_op_d = 1'b1;
                end
            endcase
        end

        if (res_we) begin
            dst_d   = res;
            dst_h_d = res_h;
            zero_d  = (res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            dst_h_q    <= '0;
            src0_out_q <= '0;
            zero_q     <= 1'b0;
            dz_q       <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            dst_h_q    <= dst_h_d;
            src0_out_q <= src0_out_d;
            zero_q     <= zero_d;
            dz_q       <= dz_d;
            bad_op_q   <= bad_op_d;
        end
    end

    assign bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.dst       = dst_q;
    assign bus.dst_h     = dst_h_q;
    assign bus.src0_out  = src0_out_q;
    assign bus.zero      = zero_q;
    assign bus.dz        = dz_q;
    assign bus.bad_op    = bad_op_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Directed stimulus with hand-computed results. The driver pushes the
//   expected response (including the edge on which done must appear) into a
//   queue; a negedge monitor pops and compares whenever done is high.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    typedef struct {
        string       tag;
        logic [W-1:0] dst;
        logic [W-1:0] dst_h;
        logic [W-1:0] s0o;
        logic        zero;
        logic        dz;
        logic        bad;
        logic        chk_s0o;
        int          done_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    alu_seq_if #(.DATA_W(W)) bus ();

    alu_seq #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".dst"},      bus.dst,      0);
        chk({tag, ".dst_h"},    bus.dst_h,    0);
        chk({tag, ".src0_out"}, bus.src0_out, 0);
        chk({tag, ".zero"},     bus.zero,     0);
        chk({tag, ".dz"},       bus.dz,       0);
        chk({tag, ".bad_op"},   bus.bad_op,   0);
        chk({tag, ".busy"},     bus.busy,     0);
        chk({tag, ".done"},     bus.done,     0);
    endtask

    // ---------------- driver ----------------
    task automatic issue(input string tag, input logic [3:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_dst, input logic [W-1:0] e_dh,
                         input logic [W-1:0] e_s0o, input logic e_z,
                         input logic e_dz, input logic e_bad,
                         input logic e_chk_s0o, input int lat);
        exp_t e;
        int   guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.issue_timeout: busy still 1 after %0d cycles, required 0", tag, guard);
        end
        bus.cmd_code = c;
        bus.src0     = a;
        bus.src1     = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        e.tag       = tag;
        e.dst       = e_dst;
        e.dst_h     = e_dh;
        e.s0o       = e_s0o;
        e.zero      = e_z;
        e.dz        = e_dz;
        e.bad       = e_bad;
        e.chk_s0o   = e_chk_s0o;
        e.done_edge = edge_cnt + lat - 1;
        exp_q.push_back(e);
        bus.start = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at edge %0d with empty queue, required done=0", edge_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.tag, ".latency"}, edge_cnt, e.done_edge);
                chk({e.tag, ".dst"},     bus.dst,   e.dst);
                chk({e.tag, ".dst_h"},   bus.dst_h, e.dst_h);
                chk({e.tag, ".zero"},    bus.zero,  e.zero);
                chk({e.tag, ".dz"},      bus.dz,    e.dz);
                chk({e.tag, ".bad_op"},  bus.bad_op, e.bad);
                if (e.chk_s0o) chk({e.tag, ".src0_out"}, bus.src0_out, e.s0o);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   busy_cnt;
        int   guard;
        exp_t dropped;

        bus.start    = 1'b0;
        bus.cmd_code = '0;
        bus.src0     = '0;
        bus.src1     = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        //      tag         cmd      src0          src1          dst           dst_h         s0o   z  dz bad chk lat
        issue("add_wrap",  CMD_ADD, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h1,        0,    1, 0, 0, 1, 1);
        issue("sub_borrow",CMD_SUB, 32'd5,        32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 0,    0, 0, 0, 1, 1);
        issue("sub_plain", CMD_SUB, 32'd7,        32'd5,        32'd2,        32'h0,        0,    0, 0, 0, 1, 1);
        issue("mul_2p32",  CMD_MUL, 32'h10000,    32'h10000,    32'h0,        32'h1,        0,    1, 0, 0, 1, 33);

        // Extra start pulses while busy must be dropped; the next request is
        // raised on the done cycle and must be taken on that edge.
        busy_cnt = 0;
        guard    = 0;
        while (guard < 100) begin
            @(negedge clk);
            guard++;
            if (!bus.busy) break;
            busy_cnt++;
            bus.start    = 1'b1;
            bus.cmd_code = CMD_ADD;
            bus.src0     = $urandom_range(0, 1000);
            bus.src1     = $urandom_range(0, 1000);
        end
        chk("mul_busy_cycles", busy_cnt, 32);

        issue("div_100_7", CMD_DIV, 32'd100,      32'd7,        32'd14,       32'd2,        0,    0, 0, 0, 1, 33);
        issue("div_by_0",  CMD_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        0,    0, 1, 0, 1, 1);
        issue("shl_40",    CMD_SHL, 32'h1,        32'd40,       32'h0,        32'h0,        0,    1, 0, 0, 1, 1);
        issue("shl_31",    CMD_SHL, 32'h1,        32'd31,       32'h80000000, 32'h0,        0,    0, 0, 0, 1, 1);
        issue("shr_4",     CMD_SHR, 32'h80000000, 32'd4,        32'h08000000, 32'h0,        0,    0, 0, 0, 1, 1);
        issue("xor",       CMD_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 32'h0,        0,    0, 0, 0, 1, 1);
        issue("and",       CMD_AND, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 32'h0,        0,    0, 0, 0, 1, 1);
        issue("or",        CMD_OR,  32'h0F000000, 32'h000000F0, 32'h0F0000F0, 32'h0,        0,    0, 0, 0, 1, 1);
        issue("bad_op",    4'hF,    32'h1,        32'h2,        32'h0F0000F0, 32'h0,        0,    0, 0, 1, 0, 1);
        issue("mul_max",   CMD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0,    0, 0, 0, 1, 33);
        issue("mul_small", CMD_MUL, 32'd12345,    32'd1000,     32'h00BC5EA8, 32'h0,        0,    0, 0, 0, 1, 33);
        issue("div_max16", CMD_DIV, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        0,    0, 0, 0, 1, 33);
        issue("div_3_5",   CMD_DIV, 32'd3,        32'd5,        32'h0,        32'd3,        0,    1, 0, 0, 1, 33);

        // Abort a divide mid-flight: its done must never appear.
        issue("div_abort", CMD_DIV, 32'd1000,     32'd3,        32'd333,      32'd1,        0,    0, 0, 0, 1, 33);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        dropped = exp_q.pop_back();
        #1;
        chk_outputs_zero("abort_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue("mov_3_9",   CMD_MOV, 32'd3,        32'd9,        32'd3,        32'h0,        32'd9, 0, 0, 0, 1, 1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
